fx_issue_scheduler: RTL and testbench

- Sits between the two decode/dispatch lanes and the fixed-point unit.
- Arbitrates round-robin between the two lanes into a small in-order issue queue.
- Tracks GPR destinations in flight in the 2-cycle FX pipeline with a 32-entry scoreboard.
- Issues at most one instruction per cycle to the FX unit once its sources are free.

---
 rtl/fx_issue_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fx_issue_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fx_issue_scheduler.sv
// fx_issue_scheduler: two-lane round-robin dispatch into an in-order issue
// queue, with a GPR scoreboard that holds instructions until their sources and
// destination are free. Issues at most one instruction per cycle to the FX unit.
module fx_issue_scheduler #(
  parameter int PAYLOAD_W = 64,
  parameter int DEPTH     = 4,
  parameter int regWidth  = 5
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          req0Valid_i,
  output logic                          req0Ready_o,
  input  logic [PAYLOAD_W-1:0]          req0Payload_i,
  input  logic [regWidth-1:0]           req0Dest_i,
  input  logic                          req0DestEn_i,
  input  logic [regWidth-1:0]           req0Src1_i,
  input  logic [regWidth-1:0]           req0Src2_i,
  input  logic [1:0]                    req0SrcEn_i,
  input  logic                          req1Valid_i,
  output logic                          req1Ready_o,
  input  logic [PAYLOAD_W-1:0]          req1Payload_i,
  input  logic [regWidth-1:0]           req1Dest_i,
  input  logic                          req1DestEn_i,
  input  logic [regWidth-1:0]           req1Src1_i,
  input  logic [regWidth-1:0]           req1Src2_i,
  input  logic [1:0]                    req1SrcEn_i,
  input  logic                          stall_i,
  input  logic                          wbValid_i,
  input  logic [regWidth-1:0]           wbAddr_i,
  output logic                          issueValid_o,
  output logic [PAYLOAD_W-1:0]          issuePayload_o,
  output logic [regWidth-1:0]           issueDest_o,
  output logic                          issueDestEn_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [(2**regWidth)-1:0]      busy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**regWidth;

  // Which lane wins when both are valid.
  typedef enum logic {
    PRI_LANE0 = 1'b0,
    PRI_LANE1 = 1'b1
  } pri_e;

  pri_e pri_q, pri_d;

  // Queue storage (data only; validity is tracked by count/pointers).
  logic [PAYLOAD_W-1:0] q_payload [DEPTH];
  logic [regWidth-1:0]  q_dest    [DEPTH];
  logic                 q_dest_en [DEPTH];
  logic [regWidth-1:0]  q_src1    [DEPTH];
  logic [regWidth-1:0]  q_src2    [DEPTH];
  logic [1:0]           q_src_en  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [NREG-1:0]  busy_q;

  logic                 can_enq, enq0, enq1, enq;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic [regWidth-1:0]  enq_dest, enq_src1, enq_src2;
  logic                 enq_dest_en;
  logic [1:0]           enq_src_en;

  logic [NREG-1:0]      wb_clr, busy_eff, busy_set;
  logic                 src1_ok, src2_ok, dest_ok, do_issue;

  // Round-robin arbiter: one enqueue per cycle, no pass-through when full.
  always_comb begin
    can_enq     = !flush_i && (count_q != CNT_W'(DEPTH));
    req0Ready_o = can_enq && req0Valid_i && (!req1Valid_i || pri_q == PRI_LANE0);
    req1Ready_o = can_enq && req1Valid_i && (!req0Valid_i || pri_q == PRI_LANE1);
    enq0        = req0Valid_i && req0Ready_o;
    enq1        = req1Valid_i && req1Ready_o;
    enq         = enq0 || enq1;
    pri_d       = pri_q;
    if (enq0)      pri_d = PRI_LANE1;
    else if (enq1) pri_d = PRI_LANE0;
    enq_payload = enq1 ? req1Payload_i : req0Payload_i;
    enq_dest    = enq1 ? req1Dest_i    : req0Dest_i;
    enq_dest_en = enq1 ? req1DestEn_i  : req0DestEn_i;
    enq_src1    = enq1 ? req1Src1_i    : req0Src1_i;
    enq_src2    = enq1 ? req1Src2_i    : req0Src2_i;
    enq_src_en  = enq1 ? req1SrcEn_i   : req0SrcEn_i;
  end

  // Head-of-queue hazard check; a same-cycle writeback counts as free.
  always_comb begin
    wb_clr   = wbValid_i ? (NREG'(1) << wbAddr_i) : '0;
    busy_eff = busy_q & ~wb_clr;
    src1_ok  = !q_src_en[rd_ptr_q][0] || !busy_eff[q_src1[rd_ptr_q]];
    src2_ok  = !q_src_en[rd_ptr_q][1] || !busy_eff[q_src2[rd_ptr_q]];
    dest_ok  = !q_dest_en[rd_ptr_q]   || !busy_eff[q_dest[rd_ptr_q]];
    do_issue = (count_q != '0) && !stall_i && !flush_i && src1_ok && src2_ok && dest_ok;
    busy_set = (do_issue && q_dest_en[rd_ptr_q]) ? (NREG'(1) << q_dest[rd_ptr_q]) : '0;
  end

  // Arbitration priority register.
  always_ff @(posedge clock_i) begin
    if (!reset_i) pri_q <= PRI_LANE0;
    else          pri_q <= pri_d;
  end

  // Queue entry write; contents need no reset since count gates visibility.
  always_ff @(posedge clock_i) begin
    if (enq) begin
      q_payload[wr_ptr_q] <= enq_payload;
      q_dest[wr_ptr_q]    <= enq_dest;
      q_dest_en[wr_ptr_q] <= enq_dest_en;
      q_src1[wr_ptr_q]    <= enq_src1;
      q_src2[wr_ptr_q]    <= enq_src2;
      q_src_en[wr_ptr_q]  <= enq_src_en;
    end
  end

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge clock_i) begin
    if (!reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq)      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq, do_issue})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Scoreboard: issue sets after writeback clears, so set wins on a collision.
  always_ff @(posedge clock_i) begin
    if (!reset_i) busy_q <= '0;
    else          busy_q <= (busy_q & ~wb_clr) | busy_set;
  end

  // Registered issue port; data holds when nothing issues.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      issueValid_o   <= 1'b0;
      issuePayload_o <= '0;
      issueDest_o    <= '0;
      issueDestEn_o  <= 1'b0;
    end else if (do_issue) begin
      issueValid_o   <= 1'b1;
      issuePayload_o <= q_payload[rd_ptr_q];
      issueDest_o    <= q_dest[rd_ptr_q];
      issueDestEn_o  <= q_dest_en[rd_ptr_q];
    end else begin
      issueValid_o   <= 1'b0;
    end
  end

  assign count_o = count_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_fx_issue_scheduler.sv
// Table-driven bench for fx_issue_scheduler with hand-computed expectations.
module tb_fx_issue_scheduler;

  localparam int PW    = 64;
  localparam int DEPTH = 4;
  localparam int RW    = 5;

  logic          clock_i = 1'b0;
  logic          reset_i, flush_i, stall_i, wbValid_i;
  logic [RW-1:0] wbAddr_i;
  logic          req0Valid_i, req0Ready_o, req0DestEn_i;
  logic [PW-1:0] req0Payload_i;
  logic [RW-1:0] req0Dest_i, req0Src1_i, req0Src2_i;
  logic [1:0]    req0SrcEn_i;
  logic          req1Valid_i, req1Ready_o, req1DestEn_i;
  logic [PW-1:0] req1Payload_i;
  logic [RW-1:0] req1Dest_i, req1Src1_i, req1Src2_i;
  logic [1:0]    req1SrcEn_i;
  logic          issueValid_o, issueDestEn_o;
  logic [PW-1:0] issuePayload_o;
  logic [RW-1:0] issueDest_o;
  logic [2:0]    count_o;
  logic [31:0]   busy_o;

  always #5 clock_i = ~clock_i;

  fx_issue_scheduler #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .regWidth(RW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
    .req0Valid_i(req0Valid_i), .req0Ready_o(req0Ready_o), .req0Payload_i(req0Payload_i),
    .req0Dest_i(req0Dest_i), .req0DestEn_i(req0DestEn_i), .req0Src1_i(req0Src1_i),
    .req0Src2_i(req0Src2_i), .req0SrcEn_i(req0SrcEn_i),
    .req1Valid_i(req1Valid_i), .req1Ready_o(req1Ready_o), .req1Payload_i(req1Payload_i),
    .req1Dest_i(req1Dest_i), .req1DestEn_i(req1DestEn_i), .req1Src1_i(req1Src1_i),
    .req1Src2_i(req1Src2_i), .req1SrcEn_i(req1SrcEn_i),
    .stall_i(stall_i), .wbValid_i(wbValid_i), .wbAddr_i(wbAddr_i),
    .issueValid_o(issueValid_o), .issuePayload_o(issuePayload_o),
    .issueDest_o(issueDest_o), .issueDestEn_o(issueDestEn_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  typedef struct {
    logic v; logic [4:0] d; logic de; logic [4:0] s1, s2; logic [1:0] se; logic [7:0] tag;
  } lane_t;

  typedef struct {
    logic rst_n, flush, stall;
    lane_t l0, l1;
    logic wb; logic [4:0] wba;
    logic er0, er1;
    int ecnt; logic eiv; logic [7:0] etag; logic [4:0] edest; logic [31:0] ebusy;
    logic zchk;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] pay(input logic [7:0] t);
    return {56'h5A5A5A5A5A5A5A, t};
  endfunction

  function automatic lane_t L(input logic [4:0] d, s1, s2, input logic [1:0] se,
                              input logic [7:0] tag);
    lane_t r;
    r.v = 1'b1; r.d = d; r.de = 1'b1; r.s1 = s1; r.s2 = s2; r.se = se; r.tag = tag;
    return r;
  endfunction

  function automatic lane_t N();
    lane_t r;
    r.v = 1'b0; r.d = '0; r.de = 1'b0; r.s1 = '0; r.s2 = '0; r.se = '0; r.tag = '0;
    return r;
  endfunction

  task automatic add(input logic rst_n, flush, stall, input lane_t l0, l1,
                     input logic wb, input logic [4:0] wba, input logic er0, er1,
                     input int ecnt, input logic eiv, input logic [7:0] etag,
                     input logic [4:0] edest, input logic [31:0] ebusy, input logic zchk);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.stall = stall; v.l0 = l0; v.l1 = l1;
    v.wb = wb; v.wba = wba; v.er0 = er0; v.er1 = er1; v.ecnt = ecnt; v.eiv = eiv;
    v.etag = etag; v.edest = edest; v.ebusy = ebusy; v.zchk = zchk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_i = v.rst_n; flush_i = v.flush; stall_i = v.stall;
    wbValid_i = v.wb; wbAddr_i = v.wba;
    req0Valid_i = v.l0.v; req0Payload_i = pay(v.l0.tag); req0Dest_i = v.l0.d;
    req0DestEn_i = v.l0.de; req0Src1_i = v.l0.s1; req0Src2_i = v.l0.s2; req0SrcEn_i = v.l0.se;
    req1Valid_i = v.l1.v; req1Payload_i = pay(v.l1.tag); req1Dest_i = v.l1.d;
    req1DestEn_i = v.l1.de; req1Src1_i = v.l1.s1; req1Src2_i = v.l1.s2; req1SrcEn_i = v.l1.se;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    int lat;

    idle.rst_n = 1'b0; idle.flush = 1'b0; idle.stall = 1'b0; idle.l0 = N(); idle.l1 = N();
    idle.wb = 1'b0; idle.wba = '0;
    drive(idle);
    repeat (2) @(posedge clock_i);
    #1;
    chk("reset count", 64'(count_o), 64'd0);
    chk("reset issueValid", 64'(issueValid_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset payload", issuePayload_o, 64'd0);
    chk("reset dest", 64'(issueDest_o), 64'd0);
    chk("reset destEn", 64'(issueDestEn_o), 64'd0);

    // single issue, then writeback of r3
    add(1,0,0, L(3,1,2,2'b11,8'h11), N(), 0,0, 1,0, 1,0,8'h00,0, 32'h0,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 0,1,8'h11,3, 32'h8,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 0,0,8'h00,0, 32'h8,0);
    add(1,0,0, N(), N(), 1,3, 0,0, 0,0,8'h00,0, 32'h0,0);
    // reset restores lane-0 priority and clears issue port
    add(0,0,0, N(), N(), 0,0, 0,0, 0,0,8'h00,0, 32'h0,1);
    // round-robin with stall, fills to DEPTH
    add(1,0,1, L(10,0,0,0,8'h20), L(11,0,0,0,8'h21), 0,0, 1,0, 1,0,8'h00,0, 32'h0,0);
    add(1,0,1, L(12,0,0,0,8'h22), L(11,0,0,0,8'h21), 0,0, 0,1, 2,0,8'h00,0, 32'h0,0);
    add(1,0,1, L(12,0,0,0,8'h22), L(13,0,0,0,8'h23), 0,0, 1,0, 3,0,8'h00,0, 32'h0,0);
    add(1,0,1, L(14,0,0,0,8'h24), L(13,0,0,0,8'h23), 0,0, 0,1, 4,0,8'h00,0, 32'h0,0);
    add(1,0,1, L(14,0,0,0,8'h24), L(15,0,0,0,8'h25), 0,0, 0,0, 4,0,8'h00,0, 32'h0,0);
    // full plus dequeue: no pass-through, ready returns next cycle
    add(1,0,0, L(14,0,0,0,8'h24), L(15,0,0,0,8'h25), 0,0, 0,0, 3,1,8'h20,10, 32'h400,0);
    add(1,0,1, L(14,0,0,0,8'h24), L(15,0,0,0,8'h25), 0,0, 1,0, 4,0,8'h00,0, 32'h400,0);
    // drain
    add(1,0,0, N(), N(), 0,0, 0,0, 3,1,8'h21,11, 32'hC00,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 2,1,8'h22,12, 32'h1C00,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 1,1,8'h23,13, 32'h3C00,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 0,1,8'h24,14, 32'h7C00,0);
    // RAW on r5 with same-cycle writeback bypass
    add(1,0,0, L(5,0,0,0,8'h30), N(), 0,0, 1,0, 1,0,8'h00,0, 32'h7C00,0);
    add(1,0,0, L(6,5,0,2'b01,8'h31), N(), 0,0, 1,0, 1,1,8'h30,5, 32'h7C20,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 1,0,8'h00,0, 32'h7C20,0);
    add(1,0,0, N(), N(), 1,5, 0,0, 0,1,8'h31,6, 32'h7C40,0);
    // WAW on r6; same-edge set and clear keeps the bit set
    add(1,0,0, L(6,0,0,0,8'h32), N(), 0,0, 1,0, 1,0,8'h00,0, 32'h7C40,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 1,0,8'h00,0, 32'h7C40,0);
    add(1,0,0, N(), N(), 1,6, 0,0, 0,1,8'h32,6, 32'h7C40,0);
    // writeback to a non-busy register is ignored
    add(1,0,0, N(), N(), 1,1, 0,0, 0,0,8'h00,0, 32'h7C40,0);
    // flush with three queued entries and r7 in flight
    add(1,0,0, L(7,0,0,0,8'h40), N(), 0,0, 1,0, 1,0,8'h00,0, 32'h7C40,0);
    add(1,0,0, L(8,0,0,0,8'h41), N(), 0,0, 1,0, 1,1,8'h40,7, 32'h7CC0,0);
    add(1,0,1, L(9,0,0,0,8'h42), N(), 0,0, 1,0, 2,0,8'h00,0, 32'h7CC0,0);
    add(1,0,1, N(), L(1,0,0,0,8'h43), 0,0, 0,1, 3,0,8'h00,0, 32'h7CC0,0);
    add(1,1,0, L(2,0,0,0,8'h44), N(), 0,0, 0,0, 0,0,8'h00,0, 32'h7CC0,0);
    add(1,0,0, N(), N(), 0,0, 0,0, 0,0,8'h00,0, 32'h7CC0,0);
    add(1,0,0, N(), N(), 1,7, 0,0, 0,0,8'h00,0, 32'h7C40,0);
    // reset mid-operation, priority left on lane 1 beforehand
    add(1,0,1, L(3,0,0,0,8'h50), N(), 0,0, 1,0, 1,0,8'h00,0, 32'h7C40,0);
    add(0,0,0, N(), N(), 0,0, 0,0, 0,0,8'h00,0, 32'h0,1);
    add(1,0,1, L(20,0,0,0,8'h60), L(21,0,0,0,8'h61), 0,0, 1,0, 1,0,8'h00,0, 32'h0,0);

    foreach (vecs[i]) begin
      @(negedge clock_i);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d ready0", i), 64'(req0Ready_o), 64'(vecs[i].er0));
      chk($sformatf("v%0d ready1", i), 64'(req1Ready_o), 64'(vecs[i].er1));
      @(posedge clock_i);
      #1;
      chk($sformatf("v%0d count", i), 64'(count_o), 64'(vecs[i].ecnt));
      chk($sformatf("v%0d issueValid", i), 64'(issueValid_o), 64'(vecs[i].eiv));
      chk($sformatf("v%0d busy", i), 64'(busy_o), 64'(vecs[i].ebusy));
      if (vecs[i].eiv) begin
        chk($sformatf("v%0d payload", i), issuePayload_o, pay(vecs[i].etag));
        chk($sformatf("v%0d dest", i), 64'(issueDest_o), 64'(vecs[i].edest));
        chk($sformatf("v%0d destEn", i), 64'(issueDestEn_o), 64'd1);
      end
      if (vecs[i].zchk) begin
        chk($sformatf("v%0d zero payload", i), issuePayload_o, 64'd0);
        chk($sformatf("v%0d zero dest", i), 64'(issueDest_o), 64'd0);
        chk($sformatf("v%0d zero destEn", i), 64'(issueDestEn_o), 64'd0);
      end
    end

    // post-reset lane-0 winner issues after one edge once the stall drops
    @(negedge clock_i);
    idle.rst_n = 1'b1;
    drive(idle);
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock_i);
      #1;
      if (issueValid_o) begin
        lat = c;
        break;
      end
    end
    chk("post-reset issue latency", 64'(lat), 64'd1);
    chk("post-reset payload", issuePayload_o, pay(8'h60));
    chk("post-reset dest", 64'(issueDest_o), 64'd20);
    chk("post-reset busy", 64'(busy_o), 64'h0010_0000);
    chk("post-reset count", 64'(count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
